// File: rtl/ctrl_pkg.sv
// Shared encodings and the per-instruction control bundle for the
// decode-to-writeback control pipeline.
package ctrl_pkg;

   localparam int unsigned REG_ADDR_W = 5;

   typedef enum logic [1:0] {
      ALUOP_LDST = 2'b00,
      ALUOP_BR   = 2'b01,
      ALUOP_R    = 2'b10,
      ALUOP_I    = 2'b11
   } alu_op_e;

   typedef enum logic [1:0] {
      FWD_RF  = 2'b00,
      FWD_WB  = 2'b01,
      FWD_MEM = 2'b10
   } fwd_sel_e;

   typedef struct packed {
      logic    Branch;
      logic    MemtoReg;
      alu_op_e ALUOp;
      logic    MemWrite;
      logic    MemRead;
      logic    ALUSrc;
      logic    RegWrite;
   } ctrl_bundle_t;

   // The younger producer (EX/MEM) wins over the older one (MEM/WB).
   function automatic fwd_sel_e fwd_pick(input logic mem_hit, input logic wb_hit);
      fwd_sel_e sel;
      sel = FWD_RF;
      if (mem_hit) begin
         sel = FWD_MEM;
      end else if (wb_hit) begin
         sel = FWD_WB;
      end
      return sel;
   endfunction

endpackage

// File: rtl/forward_unit.sv
// EX-stage operand-forwarding selection; purely combinational.
module forward_unit
   import ctrl_pkg::*;
#(
   parameter int unsigned ADDR_W = 5
) (
   input  logic [ADDR_W-1:0] exmem_rd,
   input  logic              exmem_reg_write,
   input  logic [ADDR_W-1:0] memwb_rd,
   input  logic              memwb_reg_write,
   input  logic [ADDR_W-1:0] idex_rs1,
   input  logic [ADDR_W-1:0] idex_rs2,
   output fwd_sel_e          forward_a,
   output fwd_sel_e          forward_b
);

   // RegWrite is already masked for rd = 0, so x0 can never match here.
   always_comb begin
      forward_a = fwd_pick(exmem_reg_write && (exmem_rd == idex_rs1),
                           memwb_reg_write && (memwb_rd == idex_rs1));
      forward_b = fwd_pick(exmem_reg_write && (exmem_rd == idex_rs2),
                           memwb_reg_write && (memwb_rd == idex_rs2));
   end

endmodule

// File: rtl/ctrl_pipeline.sv
// Control path from ID through WB: pipeline registers, load-use hazard
// detection with bubble insertion, and EX operand-forwarding selection.
module ctrl_pipeline #(
   parameter int unsigned REG_ADDR_W = 5,
   parameter bit          FWD_EN     = 1'b1
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  Branch_i,
   input  logic                  MemtoReg_i,
   input  logic [1:0]            ALUOp_i,
   input  logic                  MemWrite_i,
   input  logic                  ALUSrc_i,
   input  logic                  RegWrite_i,
   input  logic [REG_ADDR_W-1:0] rs1_i,
   input  logic [REG_ADDR_W-1:0] rs2_i,
   input  logic [REG_ADDR_W-1:0] rd_i,
   input  logic                  flush_i,
   output logic                  stall_o,
   output logic [1:0]            ex_ALUOp_o,
   output logic                  ex_ALUSrc_o,
   output logic [1:0]            ForwardA_o,
   output logic [1:0]            ForwardB_o,
   output logic                  mem_MemWrite_o,
   output logic                  mem_MemRead_o,
   output logic                  wb_MemtoReg_o,
   output logic                  wb_RegWrite_o,
   output logic [REG_ADDR_W-1:0] wb_rd_o
);

   import ctrl_pkg::*;

   ctrl_bundle_t          id_ctrl;
   ctrl_bundle_t          idex_ctrl;
   logic [REG_ADDR_W-1:0] idex_rs1;
   logic [REG_ADDR_W-1:0] idex_rs2;
   logic [REG_ADDR_W-1:0] idex_rd;

   logic                  exmem_mem_write;
   logic                  exmem_mem_read;
   logic                  exmem_memto_reg;
   logic                  exmem_reg_write;
   logic [REG_ADDR_W-1:0] exmem_rd;

   logic                  memwb_memto_reg;
   logic                  memwb_reg_write;
   logic [REG_ADDR_W-1:0] memwb_rd;

   logic                  hazard;
   logic                  bubble;
   logic                  unused_branch;

   always_comb begin
      id_ctrl          = '0;
      id_ctrl.Branch   = Branch_i;
      id_ctrl.MemtoReg = MemtoReg_i;
      id_ctrl.ALUOp    = alu_op_e'(ALUOp_i);
      id_ctrl.MemWrite = MemWrite_i;
      id_ctrl.MemRead  = MemtoReg_i & RegWrite_i;
      id_ctrl.ALUSrc   = ALUSrc_i;
      id_ctrl.RegWrite = RegWrite_i & (rd_i != '0);
   end

   // Both sources are compared regardless of instruction format; a flush
   // overrides the stall so the wrong-path instruction is never held.
   always_comb begin
      hazard  = idex_ctrl.MemRead && (idex_rd != '0) &&
                ((idex_rd == rs1_i) || (idex_rd == rs2_i));
      stall_o = hazard && !flush_i;
      bubble  = stall_o || flush_i;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         idex_ctrl <= '0;
         idex_rs1  <= '0;
         idex_rs2  <= '0;
         idex_rd   <= '0;
      end else if (bubble) begin
         idex_ctrl <= '0;
         idex_rs1  <= '0;
         idex_rs2  <= '0;
         idex_rd   <= '0;
      end else begin
         idex_ctrl <= id_ctrl;
         idex_rs1  <= rs1_i;
         idex_rs2  <= rs2_i;
         idex_rd   <= rd_i;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         exmem_mem_write <= 1'b0;
         exmem_mem_read  <= 1'b0;
         exmem_memto_reg <= 1'b0;
         exmem_reg_write <= 1'b0;
         exmem_rd        <= '0;
      end else begin
         exmem_mem_write <= idex_ctrl.MemWrite;
         exmem_mem_read  <= idex_ctrl.MemRead;
         exmem_memto_reg <= idex_ctrl.MemtoReg;
         exmem_reg_write <= idex_ctrl.RegWrite;
         exmem_rd        <= idex_rd;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         memwb_memto_reg <= 1'b0;
         memwb_reg_write <= 1'b0;
         memwb_rd        <= '0;
      end else begin
         memwb_memto_reg <= exmem_memto_reg;
         memwb_reg_write <= exmem_reg_write;
         memwb_rd        <= exmem_rd;
      end
   end

   // Branch is resolved in ID; it is registered only so a bubble clears it.
   assign unused_branch = idex_ctrl.Branch;

   assign ex_ALUOp_o     = idex_ctrl.ALUOp;
   assign ex_ALUSrc_o    = idex_ctrl.ALUSrc;
   assign mem_MemWrite_o = exmem_mem_write;
   assign mem_MemRead_o  = exmem_mem_read;
   assign wb_MemtoReg_o  = memwb_memto_reg;
   assign wb_RegWrite_o  = memwb_reg_write;
   assign wb_rd_o        = memwb_rd;

   if (FWD_EN) begin : g_fwd
      fwd_sel_e fwd_a;
      fwd_sel_e fwd_b;

      forward_unit #(
         .ADDR_W(REG_ADDR_W)
      ) u_forward_unit (
         .exmem_rd        (exmem_rd),
         .exmem_reg_write (exmem_reg_write),
         .memwb_rd        (memwb_rd),
         .memwb_reg_write (memwb_reg_write),
         .idex_rs1        (idex_rs1),
         .idex_rs2        (idex_rs2),
         .forward_a       (fwd_a),
         .forward_b       (fwd_b)
      );

      assign ForwardA_o = fwd_a;
      assign ForwardB_o = fwd_b;
   end else begin : g_no_fwd
      assign ForwardA_o = FWD_RF;
      assign ForwardB_o = FWD_RF;
   end

endmodule

// File: tb/tb_ctrl_pipeline.sv
// Self-checking bench for ctrl_pipeline: directed scenarios followed by
// random instruction streams compared against an instruction-history model.
module tb_ctrl_pipeline;

   logic       clk = 1'b0;
   logic       rst;
   logic       br, m2r, mw, asrc, rw, fl;
   logic [1:0] aop;
   logic [4:0] rs1, rs2, rd;

   logic       stall, ex_asrc, mem_mw, mem_mr, wb_m2r, wb_rw;
   logic [1:0] ex_aop, fa, fb;
   logic [4:0] wb_rd;

   logic       n_stall, n_ex_asrc, n_mem_mw, n_mem_mr, n_wb_m2r, n_wb_rw;
   logic [1:0] n_ex_aop, n_fa, n_fb;
   logic [4:0] n_wb_rd;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   ctrl_pipeline #(.REG_ADDR_W(5), .FWD_EN(1'b1)) u_dut (
      .clk_i(clk), .rst_i(rst), .Branch_i(br), .MemtoReg_i(m2r), .ALUOp_i(aop),
      .MemWrite_i(mw), .ALUSrc_i(asrc), .RegWrite_i(rw), .rs1_i(rs1), .rs2_i(rs2),
      .rd_i(rd), .flush_i(fl), .stall_o(stall), .ex_ALUOp_o(ex_aop),
      .ex_ALUSrc_o(ex_asrc), .ForwardA_o(fa), .ForwardB_o(fb),
      .mem_MemWrite_o(mem_mw), .mem_MemRead_o(mem_mr), .wb_MemtoReg_o(wb_m2r),
      .wb_RegWrite_o(wb_rw), .wb_rd_o(wb_rd)
   );

   ctrl_pipeline #(.REG_ADDR_W(5), .FWD_EN(1'b0)) u_nofwd (
      .clk_i(clk), .rst_i(rst), .Branch_i(br), .MemtoReg_i(m2r), .ALUOp_i(aop),
      .MemWrite_i(mw), .ALUSrc_i(asrc), .RegWrite_i(rw), .rs1_i(rs1), .rs2_i(rs2),
      .rd_i(rd), .flush_i(fl), .stall_o(n_stall), .ex_ALUOp_o(n_ex_aop),
      .ex_ALUSrc_o(n_ex_asrc), .ForwardA_o(n_fa), .ForwardB_o(n_fb),
      .mem_MemWrite_o(n_mem_mw), .mem_MemRead_o(n_mem_mr), .wb_MemtoReg_o(n_wb_m2r),
      .wb_RegWrite_o(n_wb_rw), .wb_rd_o(n_wb_rd)
   );

   typedef struct packed {
      bit br; bit m2r; bit [1:0] aop; bit mw; bit asrc; bit rw;
      bit [4:0] rs1; bit [4:0] rs2; bit [4:0] rd; bit fl;
   } ins_t;

   // One entry per instruction that entered ID/EX; index 0 is youngest.
   typedef struct packed {
      bit [1:0] aop; bit asrc; bit mw; bit mr; bit m2r; bit rw;
      bit [4:0] rs1; bit [4:0] rs2; bit [4:0] rd;
   } rec_t;

   rec_t hist[$];

   function automatic ins_t mk(input bit m2r_v, input bit [1:0] aop_v, input bit mw_v,
                               input bit asrc_v, input bit rw_v, input bit [4:0] rs1_v,
                               input bit [4:0] rs2_v, input bit [4:0] rd_v, input bit fl_v);
      ins_t x;
      x = '0;
      x.m2r = m2r_v; x.aop = aop_v; x.mw = mw_v; x.asrc = asrc_v; x.rw = rw_v;
      x.rs1 = rs1_v; x.rs2 = rs2_v; x.rd = rd_v; x.fl = fl_v;
      return x;
   endfunction

   function automatic rec_t decode(input ins_t x);
      rec_t r;
      r.aop = x.aop; r.asrc = x.asrc; r.mw = x.mw; r.m2r = x.m2r;
      r.mr  = x.m2r && x.rw;
      r.rw  = x.rw && (x.rd != 0);
      r.rs1 = x.rs1; r.rs2 = x.rs2; r.rd = x.rd;
      return r;
   endfunction

   function automatic bit [1:0] fwd_of(input bit [4:0] src);
      if (hist[1].rw && hist[1].rd == src) return 2'b10;
      if (hist[2].rw && hist[2].rd == src) return 2'b01;
      return 2'b00;
   endfunction

   task automatic reset_model();
      hist = {};
      repeat (3) hist.push_back('0);
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input ins_t x);
      br = x.br; m2r = x.m2r; aop = x.aop; mw = x.mw; asrc = x.asrc; rw = x.rw;
      rs1 = x.rs1; rs2 = x.rs2; rd = x.rd; fl = x.fl;
   endtask

   // Called just after a falling edge; returns at the next falling edge.
   task automatic step(input ins_t x, output bit stalled);
      rec_t nr;
      bit   exp_stall;
      drive(x);
      #1;
      exp_stall = hist[0].mr && (hist[0].rd != 0) &&
                  (hist[0].rd == x.rs1 || hist[0].rd == x.rs2) && !x.fl;
      chk("stall", stall, exp_stall);
      chk("fwd_a", fa, fwd_of(hist[0].rs1));
      chk("fwd_b", fb, fwd_of(hist[0].rs2));
      chk("nofwd_a", n_fa, 2'b00);
      chk("nofwd_b", n_fb, 2'b00);
      chk("ex_aluop", ex_aop, hist[0].aop);
      chk("ex_alusrc", ex_asrc, hist[0].asrc);
      chk("mem_write", mem_mw, hist[1].mw);
      chk("mem_read", mem_mr, hist[1].mr);
      chk("wb_memtoreg", wb_m2r, hist[2].m2r);
      chk("wb_regwrite", wb_rw, hist[2].rw);
      chk("wb_rd", wb_rd, hist[2].rd);
      @(posedge clk);
      nr = (exp_stall || x.fl) ? rec_t'('0) : decode(x);
      hist.push_front(nr);
      void'(hist.pop_back());
      stalled = exp_stall;
      @(negedge clk);
   endtask

   task automatic reset_mid();
      rst = 1'b1;
      #1;
      reset_model();
      chk("rst_mem_write", mem_mw, 1'b0);
      chk("rst_mem_read", mem_mr, 1'b0);
      chk("rst_stall", stall, 1'b0);
      chk("rst_ex_aluop", ex_aop, 2'b00);
      chk("rst_wb_regwrite", wb_rw, 1'b0);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      ins_t nop, x, last;
      bit   s, last_stall;
      nop = '0;
      drive(nop);
      rst = 1'b0;
      #1 rst = 1'b1;
      #1;
      reset_model();
      chk("reset_ex_aluop", ex_aop, 2'b00);
      chk("reset_fwd_a", fa, 2'b00);
      chk("reset_mem_read", mem_mr, 1'b0);
      chk("reset_wb_regwrite", wb_rw, 1'b0);
      chk("reset_wb_rd", wb_rd, 5'd0);
      @(negedge clk);
      rst = 1'b0;

      // add x5: latency to EX and WB
      step(mk(0, 2'b10, 0, 0, 1, 5'd1, 5'd2, 5'd5, 0), s);
      chk("lat_ex_aluop", ex_aop, 2'b10);
      step(nop, s);
      step(nop, s);
      chk("lat_wb_regwrite", wb_rw, 1'b1);
      chk("lat_wb_rd", wb_rd, 5'd5);

      // back-to-back dependency forwards from EX/MEM
      step(mk(0, 2'b10, 0, 0, 1, 5'd1, 5'd2, 5'd5, 0), s);
      step(mk(0, 2'b10, 0, 0, 1, 5'd5, 5'd3, 5'd7, 0), s);
      chk("fwd_exmem", fa, 2'b10);

      // one nop between producer and consumer forwards from MEM/WB
      step(mk(0, 2'b10, 0, 0, 1, 5'd1, 5'd2, 5'd5, 0), s);
      step(nop, s);
      step(mk(0, 2'b10, 0, 0, 1, 5'd5, 5'd3, 5'd7, 0), s);
      chk("fwd_memwb", fa, 2'b01);

      // load-use: one-cycle stall, bubble, then forward from MEM/WB
      step(mk(1, 2'b00, 0, 1, 1, 5'd1, 5'd0, 5'd6, 0), s);
      x = mk(0, 2'b10, 0, 0, 1, 5'd1, 5'd6, 5'd8, 0);
      drive(x);
      #1 chk("lu_stall_on", stall, 1'b1);
      step(x, s);
      chk("lu_bubble_aluop", ex_aop, 2'b00);
      chk("lu_bubble_alusrc", ex_asrc, 1'b0);
      drive(x);
      #1 chk("lu_stall_off", stall, 1'b0);
      step(x, s);
      chk("lu_fwd_b", fb, 2'b01);

      // flush beats stall
      step(mk(1, 2'b00, 0, 1, 1, 5'd1, 5'd0, 5'd6, 0), s);
      x = mk(0, 2'b10, 0, 0, 1, 5'd6, 5'd2, 5'd9, 1);
      drive(x);
      #1 chk("flush_stall", stall, 1'b0);
      step(x, s);
      chk("flush_bubble", ex_aop, 2'b00);
      chk("flush_fwd_a", fa, 2'b00);
      chk("flush_fwd_b", fb, 2'b00);

      // writes to x0 never forward or reach WB
      step(mk(0, 2'b10, 0, 0, 1, 5'd1, 5'd2, 5'd0, 0), s);
      step(mk(0, 2'b10, 0, 0, 1, 5'd0, 5'd3, 5'd3, 0), s);
      chk("x0_fwd_a", fa, 2'b00);
      step(nop, s);
      chk("x0_wb_regwrite", wb_rw, 1'b0);

      // reset with a store in EX/MEM and a load in ID/EX
      step(mk(0, 2'b00, 1, 1, 0, 5'd1, 5'd2, 5'd0, 0), s);
      step(mk(1, 2'b00, 0, 1, 1, 5'd1, 5'd0, 5'd6, 0), s);
      drive(mk(0, 2'b10, 0, 0, 1, 5'd6, 5'd2, 5'd4, 0));
      #1;
      chk("pre_rst_stall", stall, 1'b1);
      chk("pre_rst_mem_write", mem_mw, 1'b1);
      reset_mid();
      repeat (3) step(nop, s);
      chk("post_rst_mem_write", mem_mw, 1'b0);

      // random streams over a small register set to provoke hazards
      last = nop;
      last_stall = 1'b0;
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 99) == 0) begin
            reset_mid();
            last_stall = 1'b0;
         end
         if (last_stall) begin
            x = last;
         end else begin
            x.br = 1'($urandom); x.m2r = 1'($urandom); x.aop = 2'($urandom);
            x.mw = 1'($urandom); x.asrc = 1'($urandom); x.rw = 1'($urandom);
            x.rs1 = 5'($urandom_range(0, 3)); x.rs2 = 5'($urandom_range(0, 3));
            x.rd = 5'($urandom_range(0, 3));
         end
         x.fl = ($urandom_range(0, 9) == 0);
         step(x, s);
         last = x;
         last_stall = s;
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
